// File: rtl/cmp_alarm_fsm.sv
`default_nettype none
// ============================================================================
// Module   : cmp_alarm_fsm
// Brief    : Run-length hysteresis alarm on qualified gt/lt/eq comparator flags,
//            with rise/fall pulses and a sticky malformed-sample error flag.
//            Optional macro CMP_ALARM_EVT_CNT_EN adds a saturating rise counter.
// Revision : 1.0 - initial release
// ============================================================================
module cmp_alarm_fsm #(
    parameter int CNT_W      = 4,
    parameter int ASSERT_CNT = 3,
    parameter int CLEAR_CNT  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             gt,
    input  logic             lt,
    input  logic             eq,
    input  logic             err_clr,
    output logic             alarm,
    output logic             alarm_rise,
    output logic             alarm_fall,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] run_cnt,
    output logic             err
`ifdef CMP_ALARM_EVT_CNT_EN
    ,
    output logic [7:0]       evt_cnt
`endif
);

    localparam int C_CNT_MAX = (1 << CNT_W) - 1;
    localparam logic [CNT_W-1:0] C_ASSERT_CNT = CNT_W'(ASSERT_CNT);
    localparam logic [CNT_W-1:0] C_CLEAR_CNT  = CNT_W'(CLEAR_CNT);
    localparam logic [CNT_W-1:0] C_ONE        = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PEND_HI = 2'd1,
        S_ALARM   = 2'd2,
        S_PEND_LO = 2'd3
    } state_t;

    if (ASSERT_CNT < 1 || ASSERT_CNT > C_CNT_MAX ||
        CLEAR_CNT  < 1 || CLEAR_CNT  > C_CNT_MAX) begin : g_bad_params
        $fatal(1, "cmp_alarm_fsm: ASSERT_CNT/CLEAR_CNT out of range 1..2^CNT_W-1");
    end

    state_t           state_q, state_d;
    logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
    logic             alarm_q, alarm_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             err_q, err_d;
    logic             w_legal, w_take, w_bad;
    logic [CNT_W-1:0] w_cnt_inc;

    // Exactly one flag set; anything else is a malformed sample.
    assign w_legal   = (gt & ~lt & ~eq) | (~gt & lt & ~eq) | (~gt & ~lt & eq);
    assign w_take    = in_valid & w_legal;
    assign w_bad     = in_valid & ~w_legal;
    assign w_cnt_inc = run_cnt_q + C_ONE;

    always_comb begin
        state_d   = state_q;
        run_cnt_d = run_cnt_q;
        if (w_take) begin
            case (state_q)
                S_IDLE: begin
                    run_cnt_d = '0;
                    if (gt) begin
                        if (ASSERT_CNT == 1) begin
                            state_d = S_ALARM;
                        end else begin
                            state_d   = S_PEND_HI;
                            run_cnt_d = C_ONE;
                        end
                    end
                end
                S_PEND_HI: begin
                    if (gt) begin
                        if (w_cnt_inc == C_ASSERT_CNT) begin
                            state_d   = S_ALARM;
                            run_cnt_d = '0;
                        end else begin
                            run_cnt_d = w_cnt_inc;
                        end
                    end else begin
                        state_d   = S_IDLE;
                        run_cnt_d = '0;
                    end
                end
                S_ALARM: begin
                    run_cnt_d = '0;
                    if (lt) begin
                        if (CLEAR_CNT == 1) begin
                            state_d = S_IDLE;
                        end else begin
                            state_d   = S_PEND_LO;
                            run_cnt_d = C_ONE;
                        end
                    end
                end
                default: begin
                    if (lt) begin
                        if (w_cnt_inc == C_CLEAR_CNT) begin
                            state_d   = S_IDLE;
                            run_cnt_d = '0;
                        end else begin
                            run_cnt_d = w_cnt_inc;
                        end
                    end else begin
                        state_d   = S_ALARM;
                        run_cnt_d = '0;
                    end
                end
            endcase
        end
    end

    // Pulses come from the level change so rise and fall are mutually exclusive.
    always_comb begin
        alarm_d = (state_d == S_ALARM) || (state_d == S_PEND_LO);
        rise_d  = alarm_d & ~alarm_q;
        fall_d  = ~alarm_d & alarm_q;
        err_d   = w_bad ? 1'b1 : (err_clr ? 1'b0 : err_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            run_cnt_q <= '0;
            alarm_q   <= 1'b0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_cnt_q <= run_cnt_d;
            alarm_q   <= alarm_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            err_q     <= err_d;
        end
    end

    assign state      = state_q;
    assign run_cnt    = run_cnt_q;
    assign alarm      = alarm_q;
    assign alarm_rise = rise_q;
    assign alarm_fall = fall_q;
    assign err        = err_q;

`ifdef CMP_ALARM_EVT_CNT_EN
    logic [7:0] evt_cnt_q, evt_cnt_d;

    always_comb begin
        evt_cnt_d = evt_cnt_q;
        if (err_clr) begin
            evt_cnt_d = 8'd0;
        end else if (rise_d && (evt_cnt_q != 8'hFF)) begin
            evt_cnt_d = evt_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_cnt_q <= 8'd0;
        end else begin
            evt_cnt_q <= evt_cnt_d;
        end
    end

    assign evt_cnt = evt_cnt_q;
`endif

endmodule
`default_nettype wire
